wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width; only 32 is supported.
REQ-002 SHALL have ports: clk  in  1  clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: mem_valid  in  1  MEM-stage instruction present; mem_ready  out  1  stage accepts this cycle.
REQ-004 SHALL have ports: mem_rd_we  in  1  writes rd; mem_rd_addr  in  5  destination; mem_wb_sel  in  2  result source (ALU, LOAD, PC4, CSR).
REQ-005 SHALL have ports: mem_alu_result, mem_pc4, mem_csr_rdata  in  32 each  candidate results; mem_ld_funct3  in  3  load type; mem_addr_lo  in  2  byte offset.
REQ-006 SHALL have ports: dmem_rvalid  in  1  load response; dmem_rdata  in  32  raw word; dmem_err  in  1  bus error with response.
REQ-007 SHALL have ports: flush  in  1  kill held instruction; rf_wr_en  out  1; rf_rd_addr  out  5; rf_rd_data  out  32  regfile write port.
REQ-008 SHALL have ports: fwd_valid  out  1; fwd_rd_addr  out  5; fwd_data  out  32  forwarding source for hazard unit; load_fault  out  1  one-cycle error pulse.

Function
REQ-009 SHALL hold at most one instruction, with states EMPTY, HOLD (non-load result ready), WAIT_LD (load awaiting dmem_rvalid).
REQ-010 SHALL capture all mem_* fields on a rising edge when mem_valid && mem_ready && !flush.
REQ-011 On capture SHALL enter WAIT_LD if wb_sel=LOAD, else HOLD.
REQ-012 In HOLD SHALL assert rf_wr_en = held rd_we && rd_addr!=0 for exactly one cycle, then retire.
REQ-013 In WAIT_LD SHALL assert rf_wr_en only in a cycle with dmem_rvalid && !dmem_err && rd_we && rd_addr!=0, with rf_rd_data = aligned dmem_rdata combinationally.
REQ-014 Load alignment: LB/LH sign-extend, LBU/LHU zero-extend, byte selected by addr_lo, halfword by addr_lo[1], LW passes word; reserved funct3 treated as LW.
REQ-015 dmem_rvalid with dmem_err SHALL suppress the write and pulse load_fault for one cycle, then retire.
REQ-016 mem_ready SHALL be 1 in EMPTY and in any cycle the held instruction retires (HOLD, or WAIT_LD with dmem_rvalid); 0 otherwise.
REQ-017 Retire and capture in the same cycle SHALL be back-to-back: one instruction per cycle throughput for non-loads.
REQ-018 dmem_rvalid outside WAIT_LD SHALL be ignored.
REQ-019 flush SHALL return to EMPTY next edge, suppress rf_wr_en and load_fault in that cycle, and block capture; a flushed WAIT_LD discards its later response (no outstanding-request tracking beyond one).
REQ-020 fwd_valid SHALL equal rf_wr_en; fwd_rd_addr/fwd_data SHALL equal rf_rd_addr/rf_rd_data.
REQ-021 rf_rd_addr/rf_rd_data SHALL be don't-care when rf_wr_en=0 but SHALL not contain X after reset.

Reset
REQ-022 Asynchronous assertion SHALL force EMPTY; all held fields zero.
REQ-023 Outputs in reset: mem_ready=1, rf_wr_en=0, rf_rd_addr=0, rf_rd_data=0, fwd_valid=0, load_fault=0.
REQ-024 Reset during WAIT_LD SHALL abandon the load without a write.

Structure
REQ-025 wb_sel_t enum and load funct3 constants (LB, LH, LW, LBU, LHU) SHALL live in shared package brv32p_pkg.
REQ-026 Alignment SHALL be a combinational sub-module load_align (funct3, addr_lo, rdata -> data).
REQ-027 State SHALL be an enum typed register; single always_ff for state and held fields.

Verification
REQ-028 ALU instr rd=5, result 0x1234_5678 -> next cycle rf_wr_en=1, rf_rd_addr=5, data 0x1234_5678, mem_ready=1.
REQ-029 LB addr_lo=3, rdata 0x80FF_FF00, rvalid after 3 cycles -> mem_ready=0 for 3 cycles, then write 0xFFFF_FF80.
REQ-030 LHU addr_lo=2, rdata 0x8001_0000 -> write 0x0000_8001; LH same -> 0xFFFF_8001.
REQ-031 Load with dmem_err=1 -> no write, load_fault pulses once, state EMPTY next.
REQ-032 rd=0 ALU instr -> rf_wr_en=0; three consecutive ALU instrs -> three writes on three consecutive cycles.
REQ-033 flush in WAIT_LD then stray rvalid -> no write; rst_n low mid-WAIT_LD -> all outputs at reset values.

Source files
------------

// File: rtl/brv32p_pkg.sv
// Shared pipeline types for the brv32p core: writeback source select,
// load funct3 encodings and the writeback stage holding register.
package brv32p_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_CSR  = 2'd3
  } wb_sel_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_WAIT_LD = 2'd2
  } wb_state_t;

  // One in-flight instruction as captured from MEM
  typedef struct packed {
    logic        rd_we;
    logic [4:0]  rd_addr;
    wb_sel_t     wb_sel;
    logic [31:0] alu_result;
    logic [31:0] pc4;
    logic [31:0] csr_rdata;
    logic [2:0]  ld_funct3;
    logic [1:0]  addr_lo;
  } wb_entry_t;

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the byte/halfword addressed by addr_lo out of
// the raw bus word and sign- or zero-extends it. Unknown funct3 passes the word.
module load_align
  import brv32p_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select then extension by load type
  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LB:      data = {{24{byte_sel[7]}}, byte_sel};
      LH:      data = {{16{half_sel[15]}}, half_sel};
      LBU:     data = {24'd0, byte_sel};
      LHU:     data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: holds one instruction from MEM, writes the register file
// once its result is available (immediately for non-loads, on the dmem
// response for loads) and mirrors that write as the forwarding source.
module wb_stage
  import brv32p_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic            mem_rd_we,
  input  logic [4:0]      mem_rd_addr,
  input  logic [1:0]      mem_wb_sel,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_pc4,
  input  logic [XLEN-1:0] mem_csr_rdata,
  input  logic [2:0]      mem_ld_funct3,
  input  logic [1:0]      mem_addr_lo,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_err,
  input  logic            flush,
  output logic            rf_wr_en,
  output logic [4:0]      rf_rd_addr,
  output logic [XLEN-1:0] rf_rd_data,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd_addr,
  output logic [XLEN-1:0] fwd_data,
  output logic            load_fault
);

  wb_state_t   state, nxt_state;
  wb_entry_t   held;
  logic        capture, ld_done, retire, wr_ok;
  logic [31:0] ld_data, res_data;

  load_align u_align (
    .funct3  (held.ld_funct3),
    .addr_lo (held.addr_lo),
    .rdata   (dmem_rdata),
    .data    (ld_data)
  );

  // Non-load result source; held fields are zero after reset so this is 0 then
  always_comb begin
    case (held.wb_sel)
      WB_PC4:  res_data = held.pc4;
      WB_CSR:  res_data = held.csr_rdata;
      default: res_data = held.alu_result;
    endcase
  end

  // Handshake, regfile write qualification and next state
  always_comb begin
    ld_done    = (state == ST_WAIT_LD) && dmem_rvalid;
    retire     = (state == ST_HOLD) || ld_done;
    mem_ready  = (state == ST_EMPTY) || retire;
    capture    = mem_valid && mem_ready && !flush;
    wr_ok      = held.rd_we && (held.rd_addr != 5'd0) && !flush;
    rf_wr_en   = wr_ok && ((state == ST_HOLD) || (ld_done && !dmem_err));
    load_fault = !flush && ld_done && dmem_err;
    rf_rd_addr = held.rd_addr;
    rf_rd_data = (state == ST_WAIT_LD) ? ld_data : res_data;
    nxt_state  = state;
    if (flush)        nxt_state = ST_EMPTY;
    else if (capture) nxt_state = (wb_sel_t'(mem_wb_sel) == WB_LOAD) ? ST_WAIT_LD : ST_HOLD;
    else if (retire)  nxt_state = ST_EMPTY;
  end

  // Forwarding view is exactly the regfile write
  always_comb begin
    fwd_valid   = rf_wr_en;
    fwd_rd_addr = rf_rd_addr;
    fwd_data    = rf_rd_data;
  end

  // State and held instruction; fields only load on capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      held  <= '0;
    end else begin
      state <= nxt_state;
      if (capture) begin
        held.rd_we      <= mem_rd_we;
        held.rd_addr    <= mem_rd_addr;
        held.wb_sel     <= wb_sel_t'(mem_wb_sel);
        held.alu_result <= mem_alu_result;
        held.pc4        <= mem_pc4;
        held.csr_rdata  <= mem_csr_rdata;
        held.ld_funct3  <= mem_ld_funct3;
        held.addr_lo    <= mem_addr_lo;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: inputs change on the falling edge, outputs
// are checked 1ns later, so each check sees the state set by the prior
// rising edge together with the inputs of the current cycle.
module tb_wb_stage;

  logic        clk, rst_n;
  logic        mem_valid, mem_ready, mem_rd_we;
  logic [4:0]  mem_rd_addr;
  logic [1:0]  mem_wb_sel;
  logic [31:0] mem_alu_result, mem_pc4, mem_csr_rdata;
  logic [2:0]  mem_ld_funct3;
  logic [1:0]  mem_addr_lo;
  logic        dmem_rvalid, dmem_err, flush;
  logic [31:0] dmem_rdata;
  logic        rf_wr_en, fwd_valid, load_fault;
  logic [4:0]  rf_rd_addr, fwd_rd_addr;
  logic [31:0] rf_rd_data, fwd_data;

  int vectors = 0;
  int miscompares = 0;

  wb_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_rd_we(mem_rd_we), .mem_rd_addr(mem_rd_addr), .mem_wb_sel(mem_wb_sel),
    .mem_alu_result(mem_alu_result), .mem_pc4(mem_pc4), .mem_csr_rdata(mem_csr_rdata),
    .mem_ld_funct3(mem_ld_funct3), .mem_addr_lo(mem_addr_lo),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .dmem_err(dmem_err),
    .flush(flush),
    .rf_wr_en(rf_wr_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .fwd_valid(fwd_valid), .fwd_rd_addr(fwd_rd_addr), .fwd_data(fwd_data),
    .load_fault(load_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_mem();
    mem_valid = 0; mem_rd_we = 0; mem_rd_addr = 0; mem_wb_sel = 2'd0;
    mem_alu_result = 0; mem_pc4 = 0; mem_csr_rdata = 0;
    mem_ld_funct3 = 0; mem_addr_lo = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [31:0] csr,
                       input logic [2:0] f3, input logic [1:0] lo);
    mem_valid = 1; mem_rd_we = 1; mem_rd_addr = rd; mem_wb_sel = sel;
    mem_alu_result = alu; mem_pc4 = pc4; mem_csr_rdata = csr;
    mem_ld_funct3 = f3; mem_addr_lo = lo;
  endtask

  task automatic chk_write(input string tag, input logic [4:0] rd, input logic [31:0] d);
    chk({tag, ".wr_en"}, {31'd0, rf_wr_en}, 32'd1);
    chk({tag, ".addr"}, {27'd0, rf_rd_addr}, {27'd0, rd});
    chk({tag, ".data"}, rf_rd_data, d);
    chk({tag, ".fwd_v"}, {31'd0, fwd_valid}, 32'd1);
    chk({tag, ".fwd_d"}, fwd_data, d);
  endtask

  // Load from EMPTY: issue, wait waitc cycles in WAIT_LD, then respond
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] lo,
                         input logic [4:0] rd, input int waitc, input logic err,
                         input logic [31:0] rdata, input logic [31:0] exp);
    @(negedge clk); issue(rd, 2'd1, 32'hDEAD_BEEF, 32'h0, 32'h0, f3, lo);
    @(negedge clk); idle_mem();
    for (int i = 0; i < waitc; i++) begin
      #1;
      chk({tag, ".wait_ready"}, {31'd0, mem_ready}, 32'd0);
      chk({tag, ".wait_wr"}, {31'd0, rf_wr_en}, 32'd0);
      @(negedge clk);
    end
    dmem_rvalid = 1; dmem_rdata = rdata; dmem_err = err;
    #1;
    chk({tag, ".resp_ready"}, {31'd0, mem_ready}, 32'd1);
    chk({tag, ".fault"}, {31'd0, load_fault}, {31'd0, err});
    if (err) chk({tag, ".err_wr"}, {31'd0, rf_wr_en}, 32'd0);
    else     chk_write(tag, rd, exp);
    @(negedge clk); dmem_rvalid = 0; dmem_err = 0; dmem_rdata = 0;
    #1;
    chk({tag, ".after_wr"}, {31'd0, rf_wr_en}, 32'd0);
    chk({tag, ".after_fault"}, {31'd0, load_fault}, 32'd0);
    chk({tag, ".after_ready"}, {31'd0, mem_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 0; flush = 0; dmem_rvalid = 0; dmem_err = 0; dmem_rdata = 0;
    idle_mem();
    #12;
    chk("rst.ready", {31'd0, mem_ready}, 32'd1);
    chk("rst.wr_en", {31'd0, rf_wr_en}, 32'd0);
    chk("rst.addr", {27'd0, rf_rd_addr}, 32'd0);
    chk("rst.data", rf_rd_data, 32'd0);
    chk("rst.fwd_v", {31'd0, fwd_valid}, 32'd0);
    chk("rst.fault", {31'd0, load_fault}, 32'd0);
    @(negedge clk); rst_n = 1;

    // Single ALU instruction to x5
    @(negedge clk); issue(5'd5, 2'd0, 32'h1234_5678, 32'h0, 32'h0, 3'd0, 2'd0);
    #1 chk("alu.ready_in", {31'd0, mem_ready}, 32'd1);
    @(negedge clk); idle_mem();
    #1 chk_write("alu", 5'd5, 32'h1234_5678);
    chk("alu.ready", {31'd0, mem_ready}, 32'd1);
    @(negedge clk);
    #1 chk("alu.retired", {31'd0, rf_wr_en}, 32'd0);

    // rd = x0 never writes
    @(negedge clk); issue(5'd0, 2'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 3'd0, 2'd0);
    @(negedge clk); idle_mem();
    #1 chk("x0.wr_en", {31'd0, rf_wr_en}, 32'd0);

    // Three back-to-back instructions, each selecting a different source
    @(negedge clk); issue(5'd1, 2'd0, 32'hA000_0001, 32'hB000_0001, 32'hC000_0001, 3'd0, 2'd0);
    @(negedge clk);
    #1 chk_write("b2b1", 5'd1, 32'hA000_0001);
    chk("b2b1.ready", {31'd0, mem_ready}, 32'd1);
    issue(5'd2, 2'd2, 32'hA000_0002, 32'hB000_0002, 32'hC000_0002, 3'd0, 2'd0);
    @(negedge clk);
    #1 chk_write("b2b2", 5'd2, 32'hB000_0002);
    issue(5'd3, 2'd3, 32'hA000_0003, 32'hB000_0003, 32'hC000_0003, 3'd0, 2'd0);
    @(negedge clk); idle_mem();
    #1 chk_write("b2b3", 5'd3, 32'hC000_0003);
    @(negedge clk);
    #1 chk("b2b.done", {31'd0, rf_wr_en}, 32'd0);

    // Stray response while EMPTY is ignored
    dmem_rvalid = 1; dmem_err = 1; dmem_rdata = 32'h5555_5555;
    #1 chk("stray.wr", {31'd0, rf_wr_en}, 32'd0);
    chk("stray.fault", {31'd0, load_fault}, 32'd0);
    @(negedge clk); dmem_rvalid = 0; dmem_err = 0; dmem_rdata = 0;

    // Loads: alignment and extension cases
    do_load("lb3",  3'b000, 2'd3, 5'd7,  3, 1'b0, 32'h80FF_FF00, 32'hFFFF_FF80);
    do_load("lhu2", 3'b101, 2'd2, 5'd8,  1, 1'b0, 32'h8001_0000, 32'h0000_8001);
    do_load("lh2",  3'b001, 2'd2, 5'd9,  0, 1'b0, 32'h8001_0000, 32'hFFFF_8001);
    do_load("lbu1", 3'b100, 2'd1, 5'd10, 0, 1'b0, 32'h1234_8056, 32'h0000_0080);
    do_load("lh0",  3'b001, 2'd0, 5'd11, 0, 1'b0, 32'h1234_7FFE, 32'h0000_7FFE);
    do_load("lwrs", 3'b011, 2'd2, 5'd12, 2, 1'b0, 32'hCAFE_BABE, 32'hCAFE_BABE);
    do_load("err",  3'b010, 2'd0, 5'd13, 1, 1'b1, 32'h1111_1111, 32'h0);

    // Flush while waiting on a load; its late response must not write
    @(negedge clk); issue(5'd14, 2'd1, 32'h0, 32'h0, 32'h0, 3'b010, 2'd0);
    @(negedge clk); idle_mem(); flush = 1;
    #1 chk("flush.wr", {31'd0, rf_wr_en}, 32'd0);
    @(negedge clk); flush = 0; dmem_rvalid = 1; dmem_rdata = 32'h7777_7777;
    #1 chk("flush.stray_wr", {31'd0, rf_wr_en}, 32'd0);
    chk("flush.empty", {31'd0, mem_ready}, 32'd1);
    @(negedge clk); dmem_rvalid = 0; dmem_rdata = 0;

    // Flush in HOLD suppresses the write
    @(negedge clk); issue(5'd15, 2'd0, 32'h0BAD_0BAD, 32'h0, 32'h0, 3'd0, 2'd0);
    @(negedge clk); idle_mem(); flush = 1;
    #1 chk("flush_hold.wr", {31'd0, rf_wr_en}, 32'd0);
    @(negedge clk); flush = 0;

    // Reset in WAIT_LD abandons the load
    @(negedge clk); issue(5'd16, 2'd1, 32'h0, 32'h0, 32'h0, 3'b010, 2'd0);
    @(negedge clk); idle_mem();
    #1 chk("rstld.waiting", {31'd0, mem_ready}, 32'd0);
    rst_n = 0; dmem_rvalid = 1; dmem_rdata = 32'h9999_9999;
    #1;
    chk("rstld.ready", {31'd0, mem_ready}, 32'd1);
    chk("rstld.wr_en", {31'd0, rf_wr_en}, 32'd0);
    chk("rstld.addr", {27'd0, rf_rd_addr}, 32'd0);
    chk("rstld.data", rf_rd_data, 32'd0);
    chk("rstld.fwd_v", {31'd0, fwd_valid}, 32'd0);
    chk("rstld.fault", {31'd0, load_fault}, 32'd0);
    @(negedge clk); rst_n = 1; dmem_rvalid = 0; dmem_rdata = 0;
    @(negedge clk);
    #1 chk("rstld.after", {31'd0, rf_wr_en}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
